// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage load/store engine between the EX/MEM register and the data bus.
// It runs one access at a time and stalls the pipeline while that access is in
// flight. Store data is lane-replicated and given byte strobes. Load data is
// taken from the addressed lane and sign- or zero-extended. Misaligned or
// illegal accesses complete in one cycle with fault_out set, and the bus is
// never touched for them.
//
// Optional feature (compile-time macro):
//   LSU_TIMEOUT_EN - a REQ/WAIT watchdog. After TIMEOUT_CYCLES cycles without
//                    completion the access ends with fault_out=1. When the
//                    macro is undefined, REQ and WAIT wait indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES   bus wait limit in cycles (used only with LSU_TIMEOUT_EN)
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid_in    EX/MEM holds a valid memory instruction
//   is_load_in      instruction is a load
//   is_store_in     instruction is a store
//   funct3_in       RV32I width code: 0=B 1=H 2=W 4=BU 5=HU
//   addr_in         effective byte address
//   store_data_in   rs2 value
//   stall_out       freeze PC, IF/ID, ID/EX and EX/MEM
//   done_out        one-cycle completion pulse
//   load_data_out   extended load result, valid while done_out=1
//   fault_out       misaligned/illegal/timed-out, valid while done_out=1
//   dbus_*          request/response data bus (word address, byte strobes)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_in,
    input  logic        is_load_in,
    input  logic        is_store_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        stall_out,
    output logic        done_out,
    output logic [31:0] load_data_out,
    output logic        fault_out,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // A zero or negative wait limit would make the watchdog compare wrap.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [29:0] r_addr_hi;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_load_data;
    logic        r_fault;

    logic        w_start;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_fault;
    logic        w_timeout;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_shifted;
    logic [31:0] w_load_ext;

    // ---------------------------------------------------------------- decode
    assign w_start = (r_state == IDLE) && req_valid_in && (is_load_in || is_store_in);

    // funct3[1:0] carries the width: 1 = half, 2 = word (for both signednesses).
    assign w_misaligned = ((funct3_in[1:0] == 2'd1) && addr_in[0]) ||
                          ((funct3_in[1:0] == 2'd2) && (addr_in[1:0] != 2'b00));

    assign w_illegal = (is_load_in && is_store_in) ||
                       (is_load_in && ((funct3_in == 3'd3) || (funct3_in[2:1] == 2'b11))) ||
                       (is_store_in && (funct3_in >= 3'd3));

    assign w_fault = w_misaligned || w_illegal;

    // Store lane replication: every lane carries the datum, and the strobes
    // select the lanes that are actually written.
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_wdata = 32'd0;
        w_wstrb = 4'b0000;
        if (is_store_in) begin
            case (funct3_in[1:0])
                2'd0: begin
                    w_wdata = {4{store_data_in[7:0]}};
                    w_wstrb = 4'b0001 << addr_in[1:0];
                end
                2'd1: begin
                    w_wdata = {2{store_data_in[15:0]}};
                    w_wstrb = addr_in[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_wdata = store_data_in;
                    w_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // Load extraction: shift the addressed lane down to bit 0, then extend.
    assign w_shifted = dbus_rdata >> {r_addr_lo, 3'b000};

    always_comb begin
        case (r_funct3)
            3'd0:    w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'd1:    w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'd4:    w_load_ext = {24'd0, w_shifted[7:0]};
            3'd5:    w_load_ext = {16'd0, w_shifted[15:0]};
            default: w_load_ext = dbus_rdata;
        endcase
    end

    // -------------------------------------------------------------- watchdog
`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tmo_cnt;

    // The count holds the number of REQ/WAIT cycles already spent, so the
    // TIMEOUT_CYCLES-th cycle sees TIMEOUT_CYCLES-1 and leaves on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == REQ) || (r_state == WAIT)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_timeout = ((r_state == REQ) || (r_state == WAIT)) &&
                       (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // In WAIT a response arriving on the last allowed cycle still wins over
    // the watchdog; in REQ a late grant would only lead to a WAIT that times out.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_next = w_fault ? DONE : REQ;
            REQ: begin
                if (w_timeout)     w_next = DONE;
                else if (dbus_gnt) w_next = WAIT;
            end
            WAIT: if (dbus_rvalid || w_timeout) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------- datapath
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
    // NOTE: the latched bus fields are small flops, not a storage array, and are reset so that every output is 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_addr_hi   <= 30'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'b0000;
            r_load_data <= 32'd0;
            r_fault     <= 1'b0;
        end else begin
            // The result registers are non-zero only in the DONE cycle.
            r_load_data <= 32'd0;
            r_fault     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start && w_fault) begin
                        r_fault <= 1'b1;
                    end else if (w_start) begin
                        r_we      <= is_store_in;
                        r_funct3  <= funct3_in;
                        r_addr_lo <= addr_in[1:0];
                        r_addr_hi <= addr_in[31:2];
                        r_wdata   <= w_wdata;
                        r_wstrb   <= w_wstrb;
                    end
                end
                REQ: begin
                    if (w_timeout) r_fault <= 1'b1;
                end
                WAIT: begin
                    if (dbus_rvalid) begin
                        r_load_data <= r_we ? 32'd0 : w_load_ext;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    assign stall_out     = !rst && (w_start || (r_state == REQ) || (r_state == WAIT));
    assign done_out      = (r_state == DONE);
    assign load_data_out = r_load_data;
    assign fault_out     = r_fault;
    assign dbus_req      = (r_state == REQ);
    assign dbus_we       = r_we;
    assign dbus_addr     = {r_addr_hi, 2'b00};
    assign dbus_wdata    = r_wdata;
    assign dbus_wstrb    = r_wstrb;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed self-checking bench for load_store_unit. Inputs change 1 time unit
// after the rising edge. Outputs are sampled on the falling edge. "Cycle N" of
// an access counts from the cycle in which the start is presented.
// The watchdog scenario is built only when LSU_TIMEOUT_EN is defined, and the
// DUT uses TIMEOUT_CYCLES=4.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid_in;
    logic        is_load_in;
    logic        is_store_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic        stall_out;
    logic        done_out;
    logic [31:0] load_data_out;
    logic        fault_out;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_in  (req_valid_in),
        .is_load_in    (is_load_in),
        .is_store_in   (is_store_in),
        .funct3_in     (funct3_in),
        .addr_in       (addr_in),
        .store_data_in (store_data_in),
        .stall_out     (stall_out),
        .done_out      (done_out),
        .load_data_out (load_data_out),
        .fault_out     (fault_out),
        .dbus_req      (dbus_req),
        .dbus_we       (dbus_we),
        .dbus_addr     (dbus_addr),
        .dbus_wdata    (dbus_wdata),
        .dbus_wstrb    (dbus_wstrb),
        .dbus_gnt      (dbus_gnt),
        .dbus_rvalid   (dbus_rvalid),
        .dbus_rdata    (dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_in  = 1'b0;
        is_load_in    = 1'b0;
        is_store_in   = 1'b0;
        funct3_in     = 3'd0;
        addr_in       = 32'd0;
        store_data_in = 32'd0;
        dbus_gnt      = 1'b0;
        dbus_rvalid   = 1'b0;
        dbus_rdata    = 32'd0;
    endtask

    // Zero-wait access: gnt in cycle 1, rvalid in cycle 2, DONE in cycle 3.
    // The instruction stays on the inputs through DONE, as the stalled EX/MEM
    // register would hold it. Returns in the cycle after DONE.
    task automatic zw_access(input string tag, input logic ld, input logic st,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_wstrb, input logic [31:0] exp_load);
        req_valid_in  = 1'b1;
        is_load_in    = ld;
        is_store_in   = st;
        funct3_in     = f3;
        addr_in       = addr;
        store_data_in = wd;
        dbus_gnt      = 1'b0;
        dbus_rvalid   = 1'b0;
        @(negedge clk);
        check({tag, "_c0_stall_done_req"}, {stall_out, done_out, dbus_req}, 3'b100);
        cyc();
        dbus_gnt = 1'b1;
        @(negedge clk);
        check({tag, "_c1_stall_done_req"}, {stall_out, done_out, dbus_req}, 3'b101);
        check({tag, "_addr"}, dbus_addr, exp_addr);
        check({tag, "_we"}, dbus_we, st);
        check({tag, "_wstrb"}, dbus_wstrb, exp_wstrb);
        if (st) check({tag, "_wdata"}, dbus_wdata, exp_wdata);
        cyc();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = rd;
        @(negedge clk);
        check({tag, "_c2_stall_done_req"}, {stall_out, done_out, dbus_req}, 3'b100);
        cyc();
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        check({tag, "_c3_stall_done_req"}, {stall_out, done_out, dbus_req}, 3'b010);
        check({tag, "_fault"}, fault_out, 1'b0);
        check({tag, "_load_data"}, load_data_out, exp_load);
        cyc();
    endtask

    // Faulting access: DONE in cycle 1 with fault_out=1, no bus request.
    task automatic fault_access(input string tag, input logic ld, input logic st,
                                input logic [2:0] f3, input logic [31:0] addr);
        req_valid_in  = 1'b1;
        is_load_in    = ld;
        is_store_in   = st;
        funct3_in     = f3;
        addr_in       = addr;
        store_data_in = 32'h1357_9BDF;
        @(negedge clk);
        check({tag, "_c0_stall_req"}, {stall_out, dbus_req}, 2'b10);
        cyc();
        @(negedge clk);
        check({tag, "_c1_done_fault_stall_req"},
              {done_out, fault_out, stall_out, dbus_req}, 4'b1100);
        check({tag, "_load_data"}, load_data_out, 32'd0);
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) cyc();

        // Reset values, with a start pending to show stall_out is forced low.
        req_valid_in = 1'b1;
        is_load_in   = 1'b1;
        funct3_in    = 3'd2;
        @(negedge clk);
        check("rst_stall_done_req", {stall_out, done_out, dbus_req}, 3'b000);
        check("rst_fault", fault_out, 1'b0);
        check("rst_load_data", load_data_out, 32'd0);
        check("rst_wstrb", dbus_wstrb, 4'd0);
        check("rst_addr", dbus_addr, 32'd0);
        idle_inputs();
        rst = 1'b0;
        cyc();

        // Back-to-back zero-wait accesses.
        zw_access("sw",  1'b0, 1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,
                  32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000);
        zw_access("lb",  1'b1, 1'b0, 3'd0, 32'h0000_0203, 32'h0, 32'h80FF_0000,
                  32'h0000_0200, 32'h0, 4'b0000, 32'hFFFF_FF80);
        zw_access("lbu", 1'b1, 1'b0, 3'd4, 32'h0000_0203, 32'h0, 32'h80FF_0000,
                  32'h0000_0200, 32'h0, 4'b0000, 32'h0000_0080);
        zw_access("lhu", 1'b1, 1'b0, 3'd5, 32'h0000_0202, 32'h0, 32'h80FF_0000,
                  32'h0000_0200, 32'h0, 4'b0000, 32'h0000_80FF);
        zw_access("sh",  1'b0, 1'b1, 3'd1, 32'h0000_0306, 32'h1234_ABCD, 32'h0,
                  32'h0000_0304, 32'hABCD_ABCD, 4'b1100, 32'h0000_0000);
        zw_access("sb",  1'b0, 1'b1, 3'd0, 32'h0000_0101, 32'h0000_005A, 32'h0,
                  32'h0000_0100, 32'h5A5A_5A5A, 4'b0010, 32'h0000_0000);
        zw_access("lh",  1'b1, 1'b0, 3'd1, 32'h0000_0200, 32'h0, 32'h1234_8001,
                  32'h0000_0200, 32'h0, 4'b0000, 32'hFFFF_8001);
        zw_access("lw",  1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'h0, 32'hCAFE_F00D,
                  32'h0000_0400, 32'h0, 4'b0000, 32'hCAFE_F00D);
        zw_access("lbu0", 1'b1, 1'b0, 3'd4, 32'h0000_0400, 32'h0, 32'h0000_00F7,
                  32'h0000_0400, 32'h0, 4'b0000, 32'h0000_00F7);
        idle_inputs();
        cyc();

        // Faulting and illegal accesses.
        fault_access("lw_mis",   1'b1, 1'b0, 3'd2, 32'h0000_0101);
        fault_access("lh_mis",   1'b1, 1'b0, 3'd1, 32'h0000_0203);
        fault_access("sh_mis",   1'b0, 1'b1, 3'd1, 32'h0000_0301);
        fault_access("ld_f3_3",  1'b1, 1'b0, 3'd3, 32'h0000_0100);
        fault_access("st_f3_4",  1'b0, 1'b1, 3'd4, 32'h0000_0100);
        fault_access("ld_and_st", 1'b1, 1'b1, 3'd2, 32'h0000_0100);
        idle_inputs();
        cyc();

        // LW with gnt two cycles late and rvalid three cycles late: DONE in
        // cycle 8. A spurious rvalid during REQ must be ignored.
        for (int c = 0; c <= 8; c++) begin
            logic [2:0] exp_ctl;
            req_valid_in = 1'b1;
            is_load_in   = 1'b1;
            funct3_in    = 3'd2;
            addr_in      = 32'h0000_0500;
            dbus_gnt     = (c == 3);
            dbus_rvalid  = (c == 1) || (c == 2) || (c == 7);
            dbus_rdata   = (c == 7) ? 32'h1122_3344 : 32'hBAD0_BAD0;
            exp_ctl      = {c <= 7, c == 8, (c >= 1) && (c <= 3)};
            @(negedge clk);
            check($sformatf("dly_c%0d_stall_done_req", c),
                  {stall_out, done_out, dbus_req}, exp_ctl);
            if (c == 8) begin
                check("dly_load_data", load_data_out, 32'h1122_3344);
                check("dly_fault", fault_out, 1'b0);
            end
            cyc();
        end
        idle_inputs();
        cyc();

        // Reset during REQ: dbus_req and stall_out drop before the next edge.
        req_valid_in = 1'b1;
        is_load_in   = 1'b1;
        funct3_in    = 3'd2;
        addr_in      = 32'h0000_0600;
        @(negedge clk);
        cyc();
        @(negedge clk);
        check("rstreq_before", dbus_req, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rstreq_async_stall_req", {stall_out, dbus_req}, 2'b00);
        idle_inputs();
        #1 rst = 1'b0;
        cyc();
        @(negedge clk);
        check("rstreq_after_stall_done_req", {stall_out, done_out, dbus_req}, 3'b000);
        cyc();

        // Reset during WAIT, then a late rvalid: no completion.
        req_valid_in = 1'b1;
        is_load_in   = 1'b1;
        funct3_in    = 3'd2;
        addr_in      = 32'h0000_0700;
        @(negedge clk);
        cyc();
        dbus_gnt = 1'b1;
        @(negedge clk);
        cyc();
        dbus_gnt = 1'b0;
        @(negedge clk);
        check("rstwait_before_stall_done_req", {stall_out, done_out, dbus_req}, 3'b100);
        #1 rst = 1'b1;
        #1;
        check("rstwait_async_stall_req", {stall_out, dbus_req}, 2'b00);
        idle_inputs();
        #1 rst = 1'b0;
        cyc();
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h0000_0055;
        @(negedge clk);
        check("late_rvalid_stall_done_req", {stall_out, done_out, dbus_req}, 3'b000);
        cyc();
        dbus_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_next_done_fault", {done_out, fault_out}, 2'b00);
        check("late_rvalid_load_data", load_data_out, 32'd0);
        cyc();

`ifdef LSU_TIMEOUT_EN
        // gnt tied low: REQ in cycles 1-4, timed-out DONE in cycle 5.
        for (int c = 0; c <= 5; c++) begin
            logic [3:0] exp_tmo;
            req_valid_in = 1'b1;
            is_load_in   = 1'b1;
            funct3_in    = 3'd2;
            addr_in      = 32'h0000_0800;
            exp_tmo      = (c == 0) ? 4'b1000 : (c <= 4) ? 4'b1010 : 4'b0101;
            @(negedge clk);
            check($sformatf("tmo_c%0d_stall_done_req_fault", c),
                  {stall_out, done_out, dbus_req, fault_out}, exp_tmo);
            if (c == 5) check("tmo_load_data", load_data_out, 32'd0);
            cyc();
        end
        idle_inputs();
        cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store engine that sits between the EX/MEM pipeline register and the data bus and produces the load data captured by MEM/WB. It accepts one load or store at a time and holds the pipeline with a stall while the transaction is in flight. It aligns store data and byte strobes, extracts and sign- or zero-extends load data, and flags misaligned or illegal accesses without touching the bus.

## Interface
- TIMEOUT_CYCLES, 64: bus wait limit in cycles. Used only with LSU_TIMEOUT_EN.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid_in  in  1  EX/MEM holds a valid memory instruction
- is_load_in  in  1  instruction is a load
- is_store_in  in  1  instruction is a store
- funct3_in  in  3  RV32I width code: 0=B, 1=H, 2=W, 4=BU, 5=HU
- addr_in  in  32  effective byte address
- store_data_in  in  32  rs2 value
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- done_out  out  1  one-cycle completion pulse
- load_data_out  out  32  extended load result, valid while done_out=1
- fault_out  out  1  misaligned, illegal or timed-out access, valid while done_out=1
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  32  word address, {addr[31:2],2'b00}
- dbus_wdata  out  32  lane-replicated store data
- dbus_wstrb  out  4  byte enables; 0 for reads
- dbus_gnt  in  1  request accepted this cycle
- dbus_rvalid  in  1  response or write-ack valid
- dbus_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- Start condition: IDLE and req_valid_in and (is_load_in or is_store_in).
- Fault detection:
  - H/HU/SH with addr[0]=1 is misaligned.
  - W with addr[1:0]≠0 is misaligned.
  - funct3 3/6/7 on a load is illegal.
  - funct3 ≥3 on a store is illegal.
  - is_load_in and is_store_in both high is illegal.
- On a faulting start: IDLE→DONE with fault_out=1 and load_data_out=0. No bus activity.
- On a non-faulting start: IDLE→REQ. Address, we, wdata, wstrb and funct3/addr[1:0] are latched.
- REQ: dbus_req=1 with the latched fields held stable. Moves to WAIT on dbus_gnt.
- WAIT: dbus_req=0. On dbus_rvalid, dbus_rdata is captured and the FSM moves to DONE. Stores also wait for rvalid (write-ack).
- DONE: done_out=1. Always moves to IDLE next cycle. A start is never evaluated in DONE.
- Store formatting:
  - SB: wdata = byte replicated ×4, wstrb = 1<<addr[1:0].
  - SH: wdata = half replicated ×2, wstrb = 0011 or 1100 by addr[1].
  - SW: wstrb = 1111.
- Load extraction: select lane by latched addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Stores drive load_data_out=0.
- stall_out = (IDLE and start) or REQ or WAIT. It is 0 in DONE so the pipeline advances in the DONE cycle.
- dbus_rvalid and dbus_gnt are ignored in IDLE and DONE.

## Timing
- Reset values: state IDLE; all outputs 0. stall_out is forced to 0 while rst=1.
- Reset mid-transaction: dbus_req drops asynchronously. A late rvalid after reset is ignored.
- Zero-wait bus (gnt in the first REQ cycle, rvalid the next cycle):
  - Start in cycle 0; REQ in cycle 1; WAIT in cycle 2; DONE in cycle 3.
  - stall_out is high in cycles 0–2.
- Each extra gnt or rvalid wait cycle adds one cycle.
- rvalid is sampled only in WAIT, so at least 1 cycle after gnt.
- Faulting access: start in cycle 0, DONE in cycle 1. stall_out is high only in cycle 0.
- Back-to-back accesses: a new start is possible in the cycle after DONE.
- load_data_out, fault_out and done_out are registered and valid exactly in the DONE cycle.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter runs across REQ+WAIT and is cleared on leaving IDLE.
  - When it reaches TIMEOUT_CYCLES, the FSM moves to DONE with fault_out=1 and load_data_out=0. dbus_req is dropped.
- LSU_TIMEOUT_EN undefined: no counter. REQ/WAIT wait indefinitely and TIMEOUT_CYCLES is unused.

## Test plan
- SW addr=0x100, data=0xDEADBEEF, zero-wait bus -> dbus_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; done_out in cycle 3; stall_out high for 3 cycles.
- LB addr=0x203, rdata=0x80FF_0000 -> load_data_out=0xFFFFFF80. LBU same -> 0x00000080. LHU addr=0x202 -> 0x000080FF.
- SH addr=0x306, data=0x1234ABCD -> dbus_addr=0x304, wdata=0xABCDABCD, wstrb=1100.
- LW addr=0x101 -> fault_out=1, done_out in cycle 1, dbus_req never asserted.
- LW with gnt delayed 2 cycles and rvalid delayed 3 -> done_out in cycle 8. Assert rst in WAIT, then rvalid -> dbus_req=0 immediately, no done_out.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: gnt tied low -> done_out with fault_out=1 exactly 4 cycles after entering REQ.
